// File: rtl/pointwise_ctrl_k.sv
// Pointwise coefficient multiply sequencer: streams N address pairs out of banks A/B,
// multiplies them, reduces mod 3329 and writes the results back in address order.

// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads k = 0..N-1, one per non-held cycle
// DRAIN | reads finished, pipeline still emitting writes
// DONE  | one-cycle completion pulse, then back to IDLE

module red_K (
   input  logic [23:0] x_i,
   output logic [11:0] r_o
);
   logic [13:0] q;
   logic [13:0] r0;

   // Barrett with m = floor(2^24/3329): the quotient estimate is low by at most one
   assign q   = 14'((38'(x_i) * 38'd5039) >> 24);
   assign r0  = 14'(x_i - 24'(q) * 24'd3329);
   assign r_o = 12'((r0 >= 14'd3329) ? r0 - 14'd3329 : r0);
endmodule

module pointwise_ctrl_k #(
   parameter int N  = 256,
   parameter int AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic          hold_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   input  logic [11:0]   a_data_i,
   input  logic [11:0]   b_data_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [11:0]   wr_data_o
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          s1_valid_q, s1_valid_d;
   logic [AW-1:0] s1_addr_q, s1_addr_d;
   logic          s2_valid_q, s2_valid_d;
   logic [AW-1:0] s2_addr_q, s2_addr_d;
   logic [11:0]   s2_data_q, s2_data_d;

   logic          stall;
   logic          rd_en;
   logic [23:0]   prod;
   logic [11:0]   red;

   assign stall = hold_i && ((state_q == RUN) || (state_q == DRAIN));
   assign rd_en = (state_q == RUN) && !hold_i;

   // S1 tags the read issued last cycle; the banks keep its data on a/b_data_i while stalled
   assign prod = 24'(a_data_i) * 24'(b_data_i);

   red_K u_red (
      .x_i (prod),
      .r_o (red)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (!hold_i) begin
               if (cnt_q == LAST) state_d = DRAIN;
               else               cnt_d   = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!hold_i && s2_valid_q && (s2_addr_q == LAST)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_addr_d  = s1_addr_q;
      s2_valid_d = s2_valid_q;
      s2_addr_d  = s2_addr_q;
      s2_data_d  = s2_data_q;
      if (!stall) begin
         s1_valid_d = rd_en;
         s1_addr_d  = cnt_q;
         s2_valid_d = s1_valid_q;
         s2_addr_d  = s1_addr_q;
         if (s1_valid_q) s2_data_d = red;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s2_valid_q <= s2_valid_d;
         s2_addr_q  <= s2_addr_d;
         s2_data_q  <= s2_data_d;
      end
   end

   assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
   assign done_o    = (state_q == DONE);
   assign rd_en_o   = rd_en;
   assign rd_addr_o = rd_en ? cnt_q : '0;
   assign wr_en_o   = s2_valid_q && !hold_i;
   assign wr_addr_o = wr_en_o ? s2_addr_q : '0;
   assign wr_data_o = s2_data_q;
endmodule

// File: tb/tb_pointwise_ctrl_k.sv
// Directed bench for pointwise_ctrl_k: bank model, read-time scoreboard of expected
// writes, and pass-level timing checks for start, hold, ignored start and mid-pass reset.

module tb_pointwise_ctrl_k;
   localparam int N  = 256;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst, start, hold;
   logic          busy, done, rd_en, wr_en;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [11:0]   a_data, b_data, wr_data;

   typedef struct {
      int addr;
      int data;
      int cyc;
      int holds;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   a_mem [N];
   int   b_mem [N];
   int   res   [N];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   rd_exp, wr_cnt, done_cnt, done_cyc, t_start, t;
   int   hold_tot = 0;
   bit   mon_on = 1'b0;

   pointwise_ctrl_k #(.N(N), .AW(AW)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .hold_i    (hold),
      .busy_o    (busy),
      .done_o    (done),
      .rd_en_o   (rd_en),
      .rd_addr_o (rd_addr),
      .a_data_i  (a_data),
      .b_data_i  (b_data),
      .wr_en_o   (wr_en),
      .wr_addr_o (wr_addr),
      .wr_data_o (wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // registered-output banks that hold their data while not read
   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= 12'(a_mem[rd_addr]);
         b_data <= 12'(b_mem[rd_addr]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (hold && busy) begin
            chk("hold_rd_en", 32'(rd_en), 0);
            chk("hold_wr_en", 32'(wr_en), 0);
            hold_tot++;
         end
         if (!rd_en) chk("rd_addr_idle", 32'(rd_addr), 0);
         if (!wr_en) chk("wr_addr_idle", 32'(wr_addr), 0);
         if (done)   chk("busy_in_done", 32'(busy), 0);
         if (rd_en) begin
            if (rd_exp == 0) chk("first_rd_cyc", cyc, t_start + 1);
            chk("rd_addr", 32'(rd_addr), rd_exp);
            if (rd_exp < N) begin
               mon_e.addr  = rd_exp;
               mon_e.data  = (a_mem[rd_exp] * b_mem[rd_exp]) % 3329;
               mon_e.cyc   = cyc;
               mon_e.holds = hold_tot;
               sb.push_back(mon_e);
            end
            rd_exp++;
         end
         if (wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
               chk("wr_unexpected", 32'(wr_en), 0);
            end else begin
               mon_e = sb.pop_front();
               chk("wr_addr", 32'(wr_addr), mon_e.addr);
               chk("wr_data", 32'(wr_data), mon_e.data);
               chk("wr_latency", cyc - mon_e.cyc, 2 + hold_tot - mon_e.holds);
               res[wr_addr] = int'(wr_data);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clk);
      chk({tag, "_busy"},    32'(busy),    0);
      chk({tag, "_done"},    32'(done),    0);
      chk({tag, "_rd_en"},   32'(rd_en),   0);
      chk({tag, "_wr_en"},   32'(wr_en),   0);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
      chk({tag, "_wr_data"}, 32'(wr_data), 0);
   endtask

   task automatic start_pass();
      rd_exp   = 0;
      wr_cnt   = 0;
      done_cnt = 0;
      sb.delete();
      t_start  = cyc;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int extra);
      while (done_cnt == 0 && cyc < t_start + N + 60) step();
      chk("done_seen", done_cnt, 1);
      chk("done_cyc", done_cyc, t_start + N + 3 + extra);
   endtask

   task automatic end_checks();
      chk("wr_count", wr_cnt, N);
      chk("rd_count", rd_exp, N);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic fill_random();
      for (int k = 0; k < N; k++) begin
         a_mem[k] = int'($urandom_range(3328));
         b_mem[k] = int'($urandom_range(3328));
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      hold  = 1'b0;
      for (int k = 0; k < N; k++) begin
         a_mem[k] = k;
         b_mem[k] = k;
         res[k]   = -1;
      end
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;
      step();
      mon_on = 1'b1;

      // squares of the address
      start_pass();
      wait_done(0);
      end_checks();
      chk("sq_addr100", res[100], 13);
      chk("sq_addr255", res[255], 1774);

      // reduction corner values
      fill_random();
      a_mem[0] = 3328; b_mem[0] = 3328;
      a_mem[1] = 3328; b_mem[1] = 2;
      a_mem[2] = 1234; b_mem[2] = 2;
      a_mem[3] = 0;    b_mem[3] = 3000;
      step();
      start_pass();
      wait_done(0);
      end_checks();
      chk("corner0", res[0], 1);
      chk("corner1", res[1], 3327);
      chk("corner2", res[2], 2468);
      chk("corner3", res[3], 0);

      // five held cycles at the read of address 10, then hold during DONE
      fill_random();
      step();
      start_pass();
      t = t_start;
      wait_cyc(t + 11);
      hold = 1'b1;
      wait_cyc(t + 16);
      hold = 1'b0;
      wait_cyc(t + 264);
      hold = 1'b1;
      @(negedge clk);
      chk("hold_done_on_time", 32'(done), 1);
      step();
      @(negedge clk);
      chk("hold_done_one_cycle", 32'(done), 0);
      chk("hold_idle_busy", 32'(busy), 0);
      hold = 1'b0;
      step();
      chk("hold_done_cnt", done_cnt, 1);
      chk("hold_done_cyc", done_cyc, t + 264);
      end_checks();

      // start pulses mid-pass and in DONE are ignored
      fill_random();
      step();
      start_pass();
      t = t_start;
      wait_cyc(t + 50);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_cyc(t + 259);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_cyc(t + 290);
      chk("ign_done_cnt", done_cnt, 1);
      chk("ign_done_cyc", done_cyc, t + 259);
      chk("ign_busy", 32'(busy), 0);
      end_checks();

      // reset mid-pass aborts it; a fresh pass then completes
      fill_random();
      step();
      start_pass();
      t = t_start;
      wait_cyc(t + 100);
      rst = 1'b1;
      step();
      rst = 1'b0;
      sb.delete();
      chk_zero("abort");
      step();
      wait_cyc(t + 400);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_wr_cnt", wr_cnt, 98);
      chk("abort_busy", 32'(busy), 0);
      fill_random();
      step();
      start_pass();
      wait_done(0);
      end_checks();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/pointwise_ctrl_k.md
POINTWISE_CTRL_K -- requirements
Module: pointwise_ctrl_k

Interface
REQ-001 SHALL have parameter N, default 256, number of coefficients per polynomial.
REQ-002 SHALL have parameter AW, default 8, address width (2^AW >= N).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, request one pointwise-multiply pass.
REQ-006 SHALL have port hold_i, input, 1, freeze the pass (backpressure).
REQ-007 SHALL have port busy_o, output, 1, pass in progress.
REQ-008 SHALL have port done_o, output, 1, one-cycle pass-complete pulse.
REQ-009 SHALL have port rd_en_o, output, 1, read strobe to coefficient banks A and B.
REQ-010 SHALL have port rd_addr_o, output, AW, read address shared by both banks.
REQ-011 SHALL have port a_data_i, input, 12, bank A read data, valid one cycle after rd_en_o and held while rd_en_o is low.
REQ-012 SHALL have port b_data_i, input, 12, bank B read data, same timing as a_data_i.
REQ-013 SHALL have port wr_en_o, output, 1, result write strobe.
REQ-014 SHALL have port wr_addr_o, output, AW, result write address.
REQ-015 SHALL have port wr_data_o, output, 12, result coefficient.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL go IDLE->RUN on start_i=1; start_i SHALL be ignored in every other state.
REQ-018 In RUN, each non-held cycle SHALL assert rd_en_o with rd_addr_o = k, for k = 0..N-1 in order.
REQ-019 SHALL go RUN->DRAIN after issuing address N-1.
REQ-020 SHALL stay in DRAIN until the last write is issued, then go to DONE.
REQ-021 SHALL go DONE->IDLE unconditionally after one cycle.
REQ-022 Pipeline: stage S1 SHALL register a_data_i*b_data_i (24-bit) with its address one cycle after the read; stage S2 SHALL register red_K(S1 product) (12-bit) with its address.
REQ-023 wr_data_o SHALL equal (a*b) mod 3329, computed by one instantiated red_K; inputs are guaranteed < 3329.
REQ-024 wr_en_o SHALL equal S2 valid AND NOT hold_i; wr_addr_o SHALL equal the address of the S2 entry.
REQ-025 Latency: a read issued in cycle c SHALL produce its write in cycle c+2 when no hold occurs.
REQ-026 With no hold, start_i in cycle t SHALL give reads in t+1..t+N, writes in t+3..t+N+2, and done_o=1 in t+N+3.
REQ-027 busy_o SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE; done_o SHALL be 1 only in DONE.
REQ-028 hold_i=1 in RUN or DRAIN SHALL freeze FSM state, address counter, S1 and S2, and force rd_en_o=0 and wr_en_o=0.
REQ-029 hold_i SHALL have no effect in IDLE or DONE; done_o SHALL NOT be delayed by hold_i asserted in DONE.
REQ-030 rd_addr_o SHALL wrap neither past N-1 nor back to 0 within a pass; writes SHALL be exactly N, each address once, in ascending order.
REQ-031 rd_addr_o and wr_addr_o SHALL read 0 when rd_en_o or wr_en_o respectively is 0.

Reset
REQ-032 rst_i=1 SHALL force IDLE, clear the address counter, and clear S1/S2 valid and data, giving busy_o=0, done_o=0, rd_en_o=0, wr_en_o=0, all addresses and wr_data_o = 0 in the following cycle.
REQ-033 rst_i SHALL take priority over start_i and hold_i; reset mid-pass SHALL abort it with no further writes and no done_o.

Verification
REQ-034 a[k]=k, b[k]=k, start with no hold -> 256 writes, wr_data at address k = k*k mod 3329 (address 100 -> 10000-9987 = 13); done_o exactly at t+259.
REQ-035 a[0]=3328, b[0]=3328; a[1]=3328, b[1]=2; a[2]=1234, b[2]=2; a[3]=0, b[3]=3000 -> writes 1, 3327, 2468, 0.
REQ-036 hold_i high for 5 cycles starting at the cycle of read address 10 -> no rd_en/wr_en during hold, sequence resumes unchanged, done_o delayed by exactly 5 cycles (t+264).
REQ-037 start_i pulsed at t+50 and during DONE -> ignored: no restart, and exactly 256 writes.
REQ-038 rst_i for 1 cycle at t+100 -> all outputs 0 next cycle, no done_o; a new start then completes a full, correct pass.
